// File: rtl/serial_word_capture_if.sv
// ----------------------------------------------------------------------------
// serial_word_capture_if
//
// Bundles the serial input and the parallel word outputs of
// serial_word_capture.
//
// Parameter:
//   WIDTH       word length in bits; must match the attached capture block.
//
// Signals:
//   din         serial data bit (from generated_signal)
//   din_en      bit qualifier (from ENdin)
//   word_out    last completed word, held until the next completion
//   word_valid  one-cycle strobe, word_out just updated
//   abort       one-cycle strobe, partial frame discarded
//   word_count  completed words since reset, saturating
//   match       compare result for word_out      (CAPTURE_CMP_EN only)
//   err_count   mismatching words, saturating    (CAPTURE_CMP_EN only)
//
// Modports:
//   master      the side that drives the serial stream and observes words
//   slave       the capture block itself
//
// Build option: define CAPTURE_CMP_EN to add the match/err_count signals.
// ----------------------------------------------------------------------------
interface serial_word_capture_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             abort;
    logic [15:0]      word_count;
`ifdef CAPTURE_CMP_EN
    logic             match;
    logic [7:0]       err_count;

    modport master (
        output din, din_en,
        input  word_out, word_valid, abort, word_count, match, err_count
    );

    modport slave (
        input  din, din_en,
        output word_out, word_valid, abort, word_count, match, err_count
    );
`else
    modport master (
        output din, din_en,
        input  word_out, word_valid, abort, word_count
    );

    modport slave (
        input  din, din_en,
        output word_out, word_valid, abort, word_count
    );
`endif
endinterface

// File: rtl/serial_word_capture.sv
// ----------------------------------------------------------------------------
// serial_word_capture
//
// Samples a serial bit stream while its qualifier is high and packs
// consecutive enabled bits into WIDTH-bit words. Each completed word is
// presented with a one-cycle valid strobe and counted; a frame cut short by
// the qualifier dropping is discarded with a one-cycle abort strobe.
// Optionally every completed word is compared against a fixed pattern.
//
// Parameters:
//   WIDTH      word length, 2..32
//   MSB_FIRST  1: first received bit ends in word_out[WIDTH-1]
//              0: first received bit ends in word_out[0]
//   EXPECTED   reference word (low WIDTH bits used), compare build only
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   bus        serial_word_capture_if.slave (din, din_en in; word_out,
//              word_valid, abort, word_count [, match, err_count] out)
//
// Build option: define CAPTURE_CMP_EN to enable the word comparator
// (match, err_count). Without it those signals and their logic are absent
// and EXPECTED is ignored.
// ----------------------------------------------------------------------------
module serial_word_capture #(
    parameter int          WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic [31:0] EXPECTED  = 32'h0000_00A5
) (
    input  logic                          CLK,
    input  logic                          RST,
    serial_word_capture_if.slave          bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] word_out_reg, word_out_next;
    logic             word_valid_reg, word_valid_next;
    logic             abort_reg, abort_next;
    logic [15:0]      word_count_reg, word_count_next;
    logic [WIDTH-1:0] sr_shifted;
    logic             word_done;

`ifdef CAPTURE_CMP_EN
    localparam logic [WIDTH-1:0] EXPECTED_WORD = EXPECTED[WIDTH-1:0];
    logic             match_reg, match_next;
    logic [7:0]       err_count_reg, err_count_next;
`endif

    // Shift register contents after taking in the current bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shifted = {sr_reg[WIDTH-2:0], bus.din};
        end else begin : g_lsb_first
            assign sr_shifted = {bus.din, sr_reg[WIDTH-1:1]};
        end
    endgenerate

    // The bit being sampled now is the WIDTH-th of the frame. Bit 1 is always
    // taken in IDLE, so completion can only happen from SHIFT.
    assign word_done = (state_reg == SHIFT) && bus.din_en && (bit_cnt_reg == LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.din_en) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Return to IDLE both on completion and on abort; after a
                // completion the next enabled bit is picked up from IDLE with
                // no gap cycle.
                if (!bus.din_en || word_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic (next values of all registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        sr_next         = sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        word_out_next   = word_out_reg;
        word_valid_next = 1'b0;
        abort_next      = 1'b0;
        word_count_next = word_count_reg;
`ifdef CAPTURE_CMP_EN
        match_next      = match_reg;
        err_count_next  = err_count_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (bus.din_en) begin
                    sr_next      = sr_shifted;
                    bit_cnt_next = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (bus.din_en) begin
                    sr_next = sr_shifted;
                    if (word_done) begin
                        word_out_next   = sr_shifted;
                        word_valid_next = 1'b1;
                        bit_cnt_next    = '0;
                        if (word_count_reg != 16'hFFFF) begin
                            word_count_next = word_count_reg + 16'd1;
                        end
`ifdef CAPTURE_CMP_EN
                        match_next = (sr_shifted == EXPECTED_WORD);
                        if ((sr_shifted != EXPECTED_WORD) && (err_count_reg != 8'hFF)) begin
                            err_count_next = err_count_reg + 8'd1;
                        end
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end else begin
                    // Enable dropped mid-frame: throw the partial word away
                    // but leave the published word and counters alone.
                    abort_next   = 1'b1;
                    sr_next      = '0;
                    bit_cnt_next = '0;
                end
            end
            default: begin
                sr_next      = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            word_out_reg   <= '0;
            word_valid_reg <= 1'b0;
            abort_reg      <= 1'b0;
            word_count_reg <= '0;
        end else begin
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            word_out_reg   <= word_out_next;
            word_valid_reg <= word_valid_next;
            abort_reg      <= abort_next;
            word_count_reg <= word_count_next;
        end
    end

`ifdef CAPTURE_CMP_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            match_reg     <= 1'b0;
            err_count_reg <= '0;
        end else begin
            match_reg     <= match_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.match     = match_reg;
    assign bus.err_count = err_count_reg;
`endif

    assign bus.word_out   = word_out_reg;
    assign bus.word_valid = word_valid_reg;
    assign bus.abort      = abort_reg;
    assign bus.word_count = word_count_reg;

endmodule

// File: tb/tb_serial_word_capture.sv
// ----------------------------------------------------------------------------
// tb_serial_word_capture
//
// Directed bench for serial_word_capture. dut_m is the MSB-first build that
// carries most of the sequence; dut_l is an LSB-first build used for the bit
// order check. Expected words are queued as each frame is driven and popped
// when word_valid is seen.
// ----------------------------------------------------------------------------
module tb_serial_word_capture;

    logic CLK;
    logic RST;

    serial_word_capture_if #(.WIDTH(8)) bus_m ();
    serial_word_capture_if #(.WIDTH(8)) bus_l ();

    serial_word_capture #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .EXPECTED  (32'h0000_00A5)
    ) dut_m (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_m.slave)
    );

    serial_word_capture #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0),
        .EXPECTED  (32'h0000_00A5)
    ) dut_l (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_l.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          valid_cyc   = 0;
    int          prev_cyc    = 0;
    logic [15:0] exp_count   = 16'd0;
    logic [7:0]  exp_err     = 8'd0;
    logic [7:0]  exp_q[$];
    logic [7:0]  popped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock on dut_m: drive inputs, sample #1 after the edge, check strobes
    // and, on a completion, the scoreboard head.
    task automatic step(input logic d, input logic en, input logic exp_v, input logic exp_a);
        bus_m.din    = d;
        bus_m.din_en = en;
        @(posedge CLK);
        #1;
        cyc++;
        chk("word_valid", {31'd0, bus_m.word_valid}, {31'd0, exp_v});
        chk("abort", {31'd0, bus_m.abort}, {31'd0, exp_a});
        if (bus_m.word_valid) begin
            prev_cyc  = valid_cyc;
            valid_cyc = cyc;
        end
        if (exp_v) begin
            chk("scoreboard_depth", exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                chk("word_out", {24'd0, bus_m.word_out}, {24'd0, popped});
                $display("word %h count %0d", bus_m.word_out, bus_m.word_count);
            end
        end
    endtask

    // Drive a full MSB-first word with din_en high throughout.
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                exp_q.push_back(w);
                if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
                if ((w != 8'hA5) && (exp_err != 8'hFF)) exp_err = exp_err + 8'd1;
            end
            step(w[7-i], 1'b1, (i == 7), 1'b0);
        end
        chk("word_count", {16'd0, bus_m.word_count}, {16'd0, exp_count});
`ifdef CAPTURE_CMP_EN
        chk("match", {31'd0, bus_m.match}, {31'd0, (w == 8'hA5)});
        chk("err_count", {24'd0, bus_m.err_count}, {24'd0, exp_err});
`endif
    endtask

    initial begin
        RST          = 1'b1;
        bus_m.din    = 1'b0;
        bus_m.din_en = 1'b0;
        bus_l.din    = 1'b0;
        bus_l.din_en = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_word_out", {24'd0, bus_m.word_out}, 32'd0);
        chk("rst_word_valid", {31'd0, bus_m.word_valid}, 32'd0);
        chk("rst_abort", {31'd0, bus_m.abort}, 32'd0);
        chk("rst_word_count", {16'd0, bus_m.word_count}, 32'd0);
`ifdef CAPTURE_CMP_EN
        chk("rst_match", {31'd0, bus_m.match}, 32'd0);
        chk("rst_err_count", {24'd0, bus_m.err_count}, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Single word A5
        send_word(8'hA5);

        // Back-to-back A5 then 3C with no idle cycle between them
        send_word(8'hA5);
        send_word(8'h3C);
        chk("valid_spacing", valid_cyc - prev_cyc, 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Five bits then enable drops: one abort, word_out held
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_word_held", {24'd0, bus_m.word_out}, 32'h3C);
        chk("abort_count_held", {16'd0, bus_m.word_count}, {16'd0, exp_count});
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first build: 1,0,0,0,0,0,0,0 -> 8'h01
        for (int i = 0; i < 8; i++) begin
            bus_l.din    = (i == 0);
            bus_l.din_en = 1'b1;
            @(posedge CLK);
            #1;
        end
        bus_l.din_en = 1'b0;
        chk("lsb_word_valid", {31'd0, bus_l.word_valid}, 32'd1);
        chk("lsb_word_out", {24'd0, bus_l.word_out}, 32'h01);
        $display("lsb word %h count %0d", bus_l.word_out, bus_l.word_count);

        // Reset after 3 bits of a frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_word_out", {24'd0, bus_m.word_out}, 32'd0);
        chk("async_rst_word_count", {16'd0, bus_m.word_count}, 32'd0);
        chk("async_rst_abort", {31'd0, bus_m.abort}, 32'd0);
        exp_count = 16'd0;
        exp_err   = 8'd0;
        bus_m.din_en = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_no_abort", {31'd0, bus_m.abort}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // word_count saturation: preload near the top, then keep completing
        @(negedge CLK);
        force dut_m.word_count_reg = 16'hFFFE;
        @(posedge CLK);
        #1;
        release dut_m.word_count_reg;
        exp_count = 16'hFFFE;
        send_word(8'hA5);
        send_word(8'hA5);
        send_word(8'hA5);
        chk("word_count_sat", {16'd0, bus_m.word_count}, 32'h0000_FFFF);

`ifdef CAPTURE_CMP_EN
        // err_count saturation
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        force dut_m.err_count_reg = 8'hFE;
        @(posedge CLK);
        #1;
        release dut_m.err_count_reg;
        exp_err = 8'hFE;
        send_word(8'h3C);
        send_word(8'h3C);
        chk("err_count_sat", {24'd0, bus_m.err_count}, 32'h0000_00FF);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_word_capture.md
# serial_word_capture

- Receive-side stage downstream of `top`.
- Samples the serial `generated_signal` stream while its qualifier `ENdin` is high and packs consecutive enabled bits into parallel words.
- Presents each word with a one-cycle valid strobe, counts words, and flags frames cut short by early de-assertion of the enable.
- Optionally checks every word against a fixed expected pattern, so the shift-register generator can be checked in-system.

## Interface
- `WIDTH`, 8: word length in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in `word_out[WIDTH-1]`; 0 = first bit lands in `word_out[0]`.
- `EXPECTED`, 8'hA5 (zero-extended to `WIDTH`): reference word; used only when `CAPTURE_CMP_EN` is defined.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `din` input 1: serial data; connects to `generated_signal`.
- `din_en` input 1: bit qualifier; connects to `ENdin`.
- `word_out` output WIDTH: last completed word, held until the next completion.
- `word_valid` output 1: one-cycle strobe, high when `word_out` has just updated.
- `abort` output 1: one-cycle strobe, partial frame discarded.
- `word_count` output 16: completed words since reset; saturates at 16'hFFFF.
- `match` output 1 (macro only): compare result for the current `word_out`.
- `err_count` output 8 (macro only): mismatching words; saturates at 8'hFF.

## Operation
- State machine with two states, IDLE and SHIFT. There is also a bit counter `bit_cnt`, sized ceil(log2(WIDTH+1)), and a shift register `sr[WIDTH-1:0]`.
- **IDLE**:
  - `din_en`=1: sample `din` into `sr`, set `bit_cnt`=1, go to SHIFT.
  - `din_en`=0: stay in IDLE.
- **SHIFT**, `din_en`=1:
  - Shift `din` in and increment `bit_cnt`.
  - When this sample is bit number WIDTH:
    - load the completed word into `word_out`;
    - pulse `word_valid`;
    - increment `word_count`;
    - go to IDLE with `bit_cnt`=0.
- **SHIFT**, `din_en`=0 with `bit_cnt`<WIDTH:
  - pulse `abort`, clear `sr` and `bit_cnt`, go to IDLE;
  - leave `word_out`, `word_valid` and `word_count` untouched.
- Back-to-back words: when `din_en` stays high across a word boundary, the next edge samples bit 1 of the next word from IDLE. No bits are lost and there is no gap cycle.
- Shift direction:
  - `MSB_FIRST`=1: `sr` <= {`sr`[WIDTH-2:0], `din`}.
  - `MSB_FIRST`=0: `sr` <= {`din`, `sr`[WIDTH-1:1]}.
- Counters saturate and never wrap.
- `RST` asserted mid-frame discards the partial word immediately. No `abort` pulse is generated for it.

## Timing
- Reset values: state IDLE; `sr`, `bit_cnt` and `word_out` all 0; `word_valid`, `abort` and `match` all 0; `word_count` and `err_count` both 0.
- All outputs are registered; there are no combinational input-to-output paths.
- A bit is captured on each rising edge where `din_en`=1.
- Latency: `word_out`, `word_valid`, `word_count` and `match` update on the same edge that samples the WIDTH-th bit.
  - The minimum spacing between `word_valid` pulses is WIDTH cycles.
- `abort` is high for exactly the cycle after the edge that samples `din_en`=0 in SHIFT.
- `word_valid` and `abort` are never high in the same cycle.
- Inputs are assumed synchronous to `CLK`; the block has no synchronizers.

## Configuration
- Macro `CAPTURE_CMP_EN`.
- **Defined**:
  - On each completion, `match` <= (completed word == `EXPECTED`[WIDTH-1:0]).
  - `match` holds until the next completion.
  - `err_count` increments (saturating) on each mismatch, on the same edge as `word_valid`.
- **Undefined**:
  - The `match` and `err_count` ports and their logic are absent.
  - `EXPECTED` is ignored.

## Test plan
- Reset, then `din_en`=1 for 8 cycles with `din` = 1,0,1,0,0,1,0,1 (WIDTH=8, MSB_FIRST=1) -> `word_out`=8'hA5, `word_valid` high one cycle, `word_count`=1, `match`=1.
- 16 consecutive enabled cycles carrying 8'hA5 then 8'h3C -> two `word_valid` pulses exactly 8 cycles apart; `word_count`=2; with the macro, `match`=0 after the second word and `err_count`=1.
- `din_en` drops after 5 bits -> `abort` pulses once; `word_out` is unchanged. The next 8 enabled bits 8'hFF -> `word_out`=8'hFF, not corrupted by the partial frame.
- MSB_FIRST=0 with the bit sequence 1,0,0,0,0,0,0,0 -> `word_out`=8'h01.
- `RST` asserted after 3 bits, mid-frame -> all outputs 0 asynchronously with no `abort` pulse. After release, a full 8'hA5 frame captures correctly.
- Force `word_count` near saturation (65,536 words, or a reduced-width build) -> it holds at 16'hFFFF. With the macro, 256+ mismatches -> `err_count` holds at 8'hFF.
